// File: rtl/instr_fetch.sv
// Instruction fetch stage: streams words from a registered block RAM into decode.
// Ports: clk/rst, fetch_en, br_valid/br_target, id_ready, ram_* (BRAM), if_valid/if_instr/if_pc.
module instr_fetch #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             br_valid,
  input  logic [DEPTH-1:0] br_target,
  input  logic             id_ready,
  output logic             ram_en,
  output logic             ram_we,
  output logic [DEPTH-1:0] ram_ad,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [DEPTH-1:0] if_pc
);

  logic [DEPTH-1:0] pc_q, pc_d;
  logic             pend_q, pend_d;
  logic [DEPTH-1:0] pend_pc_q, pend_pc_d;
  logic             issue;

  assign ram_ad  = br_valid ? br_target : pc_q;
  // A new read may replace the pending word only once decode takes it,
  // so a stall leaves ram_en low and the RAM output frozen.
  assign issue   = !rst && (br_valid || (fetch_en && (!pend_q || id_ready)));
  assign ram_en  = issue;
  assign ram_we  = 1'b0;
  assign ram_din = '0;

  // A redirect kills whatever word is on ram_dout this cycle.
  assign if_valid = pend_q && !br_valid && !rst;
  assign if_instr = ram_dout;
  assign if_pc    = pend_pc_q;

  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (rst) begin
      pc_d      = '0;
      pend_d    = 1'b0;
      pend_pc_d = '0;
    end else if (issue) begin
      pend_d    = 1'b1;
      pend_pc_d = ram_ad;
      pc_d      = ram_ad + DEPTH'(1);
    end else if (pend_q && id_ready) begin
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    pc_q      <= pc_d;
    pend_q    <= pend_d;
    pend_pc_q <= pend_pc_d;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a registered-RAM model and
// a queue of expected delivered addresses.
module tb_instr_fetch;
  localparam int W = 18;
  localparam int D = 10;

  logic         clk;
  logic         rst;
  logic         fetch_en;
  logic         br_valid;
  logic [D-1:0] br_target;
  logic         id_ready;
  logic         ram_en;
  logic         ram_we;
  logic [D-1:0] ram_ad;
  logic [W-1:0] ram_din;
  logic [W-1:0] ram_dout;
  logic         if_valid;
  logic [W-1:0] if_instr;
  logic [D-1:0] if_pc;

  int checks = 0;
  int failures = 0;
  logic [D-1:0] sbq[$];
  logic [W-1:0] mem[1 << D];

  instr_fetch #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .br_valid(br_valid), .br_target(br_target),
    .id_ready(id_ready), .ram_en(ram_en), .ram_we(ram_we),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (ram_en) ram_dout <= mem[ram_ad];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r, input logic fe, input logic bv,
                     input logic [D-1:0] bt, input logic rdy);
    rst = r;
    fetch_en = fe;
    br_valid = bv;
    br_target = bt;
    id_ready = rdy;
    #1;
  endtask

  task automatic push_rng(input int a, input int n);
    for (int i = 0; i < n; i++) sbq.push_back(D'(a + i));
  endtask

  task automatic cyc(input logic ev);
    logic [D-1:0] a;
    chk("if_valid", {31'd0, if_valid}, {31'd0, ev});
    if (if_valid === 1'b1 && id_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        a = sbq.pop_front();
        chk("if_pc", {22'd0, if_pc}, {22'd0, a});
        chk("if_instr", {14'd0, if_instr}, {14'd0, W'(32'h100 + a)});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << D); i++) mem[i] = W'(32'h100 + i);

    // reset
    drv(1, 0, 0, 0, 0);
    chk("rst_ram_en", {31'd0, ram_en}, 0);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("ram_din", {14'd0, ram_din}, 0);
    cyc(0);

    // streaming from 0
    push_rng(0, 16);
    drv(0, 1, 0, 0, 1);
    chk("first_ad", {22'd0, ram_ad}, 0);
    chk("first_en", {31'd0, ram_en}, 1);
    cyc(0);
    for (int i = 0; i < 5; i++) cyc(1);

    // stall on 0x005
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0, 0);
      chk("stall_en", {31'd0, ram_en}, 0);
      chk("stall_pc", {22'd0, if_pc}, 5);
      chk("stall_instr", {14'd0, if_instr}, 32'h105);
      cyc(1);
    end
    drv(0, 1, 0, 0, 1);
    cyc(1);
    chk("after_stall_pc", {22'd0, if_pc}, 6);
    for (int i = 0; i < 10; i++) cyc(1);

    // redirect while 0x010 presented
    chk("pre_br_pc", {22'd0, if_pc}, 32'h010);
    push_rng(32'h200, 2);
    drv(0, 1, 1, 10'h200, 1);
    chk("br_ad", {22'd0, ram_ad}, 32'h200);
    chk("br_en", {31'd0, ram_en}, 1);
    cyc(0);
    drv(0, 1, 0, 0, 1);
    cyc(1);
    cyc(1);

    // wrap
    push_rng(32'h3FE, 2);
    push_rng(0, 2);
    drv(0, 1, 1, 10'h3FE, 1);
    cyc(0);
    drv(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1);

    // back-to-back redirects
    push_rng(32'h060, 1);
    drv(0, 1, 1, 10'h050, 1);
    cyc(0);
    drv(0, 1, 1, 10'h060, 1);
    chk("b2b_ad", {22'd0, ram_ad}, 32'h060);
    cyc(0);
    drv(0, 1, 0, 0, 1);
    cyc(1);

    // fetch_en=0 drain of 0x020
    push_rng(32'h020, 1);
    drv(0, 1, 1, 10'h020, 1);
    cyc(0);
    drv(0, 0, 0, 0, 1);
    chk("drain_en", {31'd0, ram_en}, 0);
    cyc(1);
    chk("idle_en0", {31'd0, ram_en}, 0);
    cyc(0);
    chk("idle_en1", {31'd0, ram_en}, 0);
    cyc(0);
    drv(0, 1, 0, 0, 1);
    chk("resume_ad", {22'd0, ram_ad}, 32'h021);
    chk("resume_en", {31'd0, ram_en}, 1);
    cyc(0);

    // reset during stall at 0x040
    drv(0, 1, 1, 10'h040, 1);
    cyc(0);
    drv(0, 1, 0, 0, 0);
    chk("stall40_pc", {22'd0, if_pc}, 32'h040);
    cyc(1);
    cyc(1);
    drv(1, 1, 0, 0, 0);
    chk("rst2_en", {31'd0, ram_en}, 0);
    cyc(0);
    push_rng(0, 2);
    drv(0, 1, 0, 0, 1);
    chk("post_rst_ad", {22'd0, ram_ad}, 0);
    chk("post_rst_en", {31'd0, ram_en}, 1);
    cyc(0);
    cyc(1);
    drv(0, 0, 0, 0, 1);
    cyc(1);
    cyc(0);

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end
endmodule
